// File: rtl/telemetry_slot_scheduler.sv
// Round-robin time-sharing of one 32-bit status word channel between N_SRC sources,
// with a pre-emptive priority word followed by a channel hold before the frame restarts.
module telemetry_slot_scheduler #(
    parameter int N_SRC     = 17,
    parameter int PRIO_ADDR = 17,
    parameter int SLOT_GAP  = 2,
    parameter int PRIO_HOLD = 200000,
    parameter int HOLD_W    = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [32*N_SRC-1:0]   src_data,
    input  logic [N_SRC-1:0]      src_en,
    input  logic                  prio_req,
    input  logic [31:0]           prio_data,
    output logic [31:0]           out_data,
    output logic [4:0]            out_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_done,
    output logic                  prio_active,
    output logic                  busy
);

    localparam int GAP_W = (SLOT_GAP > 1) ? $clog2(SLOT_GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((SLOT_GAP > 0) ? SLOT_GAP - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PRIO_HOLD - 1);
    localparam logic [4:0]        PRIO_A    = 5'(PRIO_ADDR);

    typedef enum logic [2:0] {
        SCAN,
        PRESENT,
        GAP,
        PRIO_LOAD,
        PRIO_PRESENT,
        HOLD
    } state_t;

    state_t             state, state_d;
    logic [4:0]         ptr, ptr_d;
    logic               prio_pending, prio_pending_d;
    logic [31:0]        prio_buf, prio_buf_d;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_d;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
    logic               sent_in_frame, sent_in_frame_d;
    logic [31:0]        out_data_d;
    logic [4:0]         out_addr_d;
    logic               out_valid_d, frame_done_d, prio_active_d;

    logic               found;
    logic [4:0]         found_idx;
    logic [31:0]        found_data;
    logic               hs;

    assign hs   = out_valid & out_ready;
    assign busy = (state != SCAN);

    // Descending walk so the lowest enabled index at or above ptr wins.
    always_comb begin
        found      = 1'b0;
        found_idx  = '0;
        found_data = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_en[i] && (5'(i) >= ptr)) begin
                found      = 1'b1;
                found_idx  = 5'(i);
                found_data = src_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d         = state;
        ptr_d           = ptr;
        prio_pending_d  = prio_pending;
        prio_buf_d      = prio_buf;
        hold_cnt_d      = hold_cnt;
        gap_cnt_d       = gap_cnt;
        sent_in_frame_d = sent_in_frame;
        out_data_d      = out_data;
        out_addr_d      = out_addr;
        out_valid_d     = out_valid;
        frame_done_d    = 1'b0;
        prio_active_d   = prio_active;

        case (state)
            SCAN: begin
                if (prio_pending) begin
                    state_d = PRIO_LOAD;
                end else if (found) begin
                    out_data_d  = found_data;
                    out_addr_d  = found_idx;
                    out_valid_d = 1'b1;
                    state_d     = PRESENT;
                end else begin
                    ptr_d           = '0;
                    frame_done_d    = sent_in_frame;
                    sent_in_frame_d = 1'b0;
                end
            end
            PRESENT: begin
                if (hs) begin
                    out_valid_d     = 1'b0;
                    ptr_d           = out_addr + 5'd1;
                    sent_in_frame_d = 1'b1;
                    gap_cnt_d       = '0;
                    state_d         = (SLOT_GAP > 0) ? GAP : SCAN;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d = SCAN;
                end else begin
                    gap_cnt_d = gap_cnt + GAP_W'(1);
                end
            end
            PRIO_LOAD: begin
                out_data_d     = prio_buf;
                out_addr_d     = PRIO_A;
                out_valid_d    = 1'b1;
                prio_pending_d = 1'b0;
                prio_active_d  = 1'b1;
                state_d        = PRIO_PRESENT;
            end
            PRIO_PRESENT: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                // A fresh request re-sends immediately; the hold restarts on its accept.
                if (prio_pending) begin
                    state_d = PRIO_LOAD;
                end else if (hold_cnt == HOLD_LAST) begin
                    ptr_d           = '0;
                    sent_in_frame_d = 1'b0;
                    prio_active_d   = 1'b0;
                    state_d         = SCAN;
                end else begin
                    hold_cnt_d = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_d = SCAN;
        endcase

        // Requests are captured in every state; a newer one overwrites the buffer.
        if (prio_req) begin
            prio_buf_d     = prio_data;
            prio_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= SCAN;
            ptr           <= '0;
            prio_pending  <= 1'b0;
            prio_buf      <= '0;
            hold_cnt      <= '0;
            gap_cnt       <= '0;
            sent_in_frame <= 1'b0;
            out_data      <= '0;
            out_addr      <= '0;
            out_valid     <= 1'b0;
            frame_done    <= 1'b0;
            prio_active   <= 1'b0;
        end else begin
            state         <= state_d;
            ptr           <= ptr_d;
            prio_pending  <= prio_pending_d;
            prio_buf      <= prio_buf_d;
            hold_cnt      <= hold_cnt_d;
            gap_cnt       <= gap_cnt_d;
            sent_in_frame <= sent_in_frame_d;
            out_data      <= out_data_d;
            out_addr      <= out_addr_d;
            out_valid     <= out_valid_d;
            frame_done    <= frame_done_d;
            prio_active   <= prio_active_d;
        end
    end

endmodule
